coin_credit: RTL and testbench
==============================

# coin_credit

Credit accumulator directly downstream of the 4-bit button debouncer in the vending machine datapath. It consumes the four debounced button levels and turns each rising edge into exactly one event: three coin buttons add credit and one button requests a refund. It holds the customer credit and serves spend requests from the vend controller. A refund handshake returns the whole credit to the change dispenser.

## Interface
- `COIN0_VAL`, default 5: credit added by `debounced[0]`, in cents
- `COIN1_VAL`, default 10: credit added by `debounced[1]`
- `COIN2_VAL`, default 25: credit added by `debounced[2]`
- `MAX_CREDIT`, default 200: credit ceiling; must be ≤ 255
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `debounced`  in  4  debounced button levels; [2:0] are coins, [3] is refund
- `spend_req`  in  1  one-cycle strobe from the vend controller
- `spend_amount`  in  8  price; sampled only when `spend_req` is high
- `refund_ack`  in  1  change dispenser accepted the refund
- `credit`  out  8  current credit, registered
- `spend_busy`  out  1  a spend is captured and not yet answered
- `spend_ok`  out  1  one-cycle pulse: spend granted and debited
- `spend_nak`  out  1  one-cycle pulse: insufficient credit, nothing debited
- `coin_reject`  out  1  one-cycle pulse: coin refused because it would exceed `MAX_CREDIT`
- `refund_valid`  out  1  refund offered; held until acknowledged
- `refund_amount`  out  8  refund value; stable while `refund_valid` is high

## Operation
- Edge detect:
  - `prev` is a 4-bit register loaded with `debounced` every cycle.
  - `rise = debounced & ~prev`.
  - `prev` resets to 4'b1111, so a button held through reset does not produce an event.
- Pending latches, 4 bits:
  - `rise[i]` sets `pend[i]`.
  - `pend[i]` is cleared only when that event is serviced.
  - A repeat edge while `pend[i]` is already set is merged into it.
- Spend capture:
  - `spend_req` while `spend_busy` is low sets `spend_busy` and captures `spend_amount`.
  - `spend_req` while `spend_busy` is high is ignored.
- States:
  - IDLE: services at most one event per cycle, in this priority: `pend[3]` (refund), then spend, then `pend[0]`, then `pend[1]`, then `pend[2]`.
  - REFUND: no events are serviced; pending coins and a captured spend wait.
- Refund in IDLE:
  - If `credit > 0`: `refund_amount <= credit`, `credit <= 0`, `refund_valid <= 1`, next state REFUND.
  - If `credit == 0`: `pend[3]` clears and nothing else happens.
- REFUND → IDLE on `refund_ack && refund_valid`; `refund_valid` drops the same edge. `refund_ack` in any other case is ignored.
- Spend:
  - If `spend_amount <= credit`: `credit -= amount` and pulse `spend_ok`.
  - Otherwise pulse `spend_nak`.
  - Either way `spend_busy` clears.
  - An amount of 0 always grants.
- Coin:
  - If `credit + COINi_VAL <= MAX_CREDIT`: add it.
  - Otherwise pulse `coin_reject` and leave credit unchanged.
  - Compute the sum 9 bits wide; no wrap-around.
- Reset mid-operation: all state clears and any unreturned credit is lost. This is an accepted behaviour.

## Timing
- Reset values:
  - outputs: `credit`, `refund_amount` = 0; `spend_busy`, `spend_ok`, `spend_nak`, `coin_reject`, `refund_valid` = 0
  - internal: `pend` = 0, state = IDLE, `prev` = 4'b1111
- Coin latency:
  - `debounced[i]` is first sampled high at edge E; `pend[i]` sets at E.
  - The earliest credit update is at E+1, later if a higher-priority event is waiting.
- Spend latency: strobe at edge E captures the request; the response pulse comes at E+1 at the earliest.
- Refund: `refund_valid` rises on the service edge; the minimum high time is 1 cycle, with ack in the next cycle.
- All outputs are registered. At most one of `spend_ok`, `spend_nak`, `coin_reject` pulses per cycle.

## Structure
- Shared `vend_pkg` holds:
  - `CREDIT_W = 8`
  - default coin value constants
  - the state enum `{ST_IDLE, ST_REFUND}`
- One sub-module, `rise_pend`: 4-bit edge detector plus pending latch, with a per-bit clear input. The arbiter, FSM and credit arithmetic sit in the `coin_credit` top.

## Test plan
- Reset held with `debounced = 4'b0001`, then release: `credit` stays 0 with no event. Then drop and re-press bit0: `credit = 5` two cycles after the edge.
- Bits 0, 1, 2 rise in the same cycle: credit goes 5, 15, 40 on three consecutive cycles.
- Credit 190, press coin2 (25): `coin_reject` pulses and credit stays 190. Then press coin1 (10): credit = 200.
- Credit 40:
  - spend 50 → `spend_nak` and credit 40;
  - spend 35 → `spend_ok` and credit 5;
  - a second `spend_req` while busy gives no extra response.
- Credit 40, press refund:
  - `refund_valid = 1`, `refund_amount = 40`, `credit = 0`;
  - a coin press during REFUND is applied only after `refund_ack`;
  - refund with credit 0 asserts no `refund_valid`.
- Assert `reset` while `refund_valid` is high: all outputs are 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-machine types and constants.
package vend_pkg;

    localparam int unsigned CREDIT_W       = 8;
    localparam int unsigned SUM_W          = CREDIT_W + 1;
    localparam int unsigned COIN0_DEF      = 5;
    localparam int unsigned COIN1_DEF      = 10;
    localparam int unsigned COIN2_DEF      = 25;
    localparam int unsigned MAX_CREDIT_DEF = 200;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REFUND = 1'b1
    } state_t;

    // Widen a credit value by one bit so a coin sum cannot wrap.
    function automatic logic [SUM_W-1:0] widen(input logic [CREDIT_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/rise_pend.sv
// Rising-edge detector with a per-bit pending latch; a set request wins over a clear.
module rise_pend (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_level,
    input  logic [3:0] i_clr,
    output logic [3:0] o_pend
);

    logic [3:0] r_prev;
    logic [3:0] r_pend;
    logic [3:0] w_rise;

    assign w_rise = i_level & ~r_prev;

    // prev resets high so a button held through reset produces no event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 4'b1111;
            r_pend <= 4'b0000;
        end else begin
            r_prev <= i_level;
            r_pend <= (r_pend & ~i_clr) | w_rise;
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/coin_credit.sv
// Credit accumulator: coin/refund events from debounced buttons, spend requests, refund handshake.
module coin_credit
    import vend_pkg::*;
#(
    parameter int unsigned COIN0_VAL  = COIN0_DEF,
    parameter int unsigned COIN1_VAL  = COIN1_DEF,
    parameter int unsigned COIN2_VAL  = COIN2_DEF,
    parameter int unsigned MAX_CREDIT = MAX_CREDIT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          debounced,
    input  logic                spend_req,
    input  logic [CREDIT_W-1:0] spend_amount,
    input  logic                refund_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                spend_busy,
    output logic                spend_ok,
    output logic                spend_nak,
    output logic                coin_reject,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount
);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_spend_amt;
    logic [CREDIT_W-1:0] r_refund_amt;
    logic                r_spend_busy;
    logic                r_spend_ok;
    logic                r_spend_nak;
    logic                r_coin_reject;
    logic                r_refund_valid;

    logic [3:0]          w_pend;
    logic [3:0]          w_clr;
    logic                w_idle;
    logic                w_svc_refund;
    logic                w_svc_spend;
    logic                w_svc_coin;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [SUM_W-1:0]    w_coin_sum;
    logic                w_coin_fits;
    logic                w_spend_fits;

    rise_pend u_rise_pend (
        .clk     (clk),
        .reset   (reset),
        .i_level (debounced),
        .i_clr   (w_clr),
        .o_pend  (w_pend)
    );

    // Arbiter: one event per cycle in IDLE, refund > spend > coin0 > coin1 > coin2.
    always_comb begin
        w_clr        = 4'b0000;
        w_coin_val   = '0;
        w_idle       = (r_state == ST_IDLE);
        w_svc_refund = w_idle && w_pend[3];
        w_svc_spend  = w_idle && !w_pend[3] && r_spend_busy;
        w_svc_coin   = w_idle && !w_pend[3] && !r_spend_busy && (|w_pend[2:0]);
        if (w_svc_refund) begin
            w_clr[3] = 1'b1;
        end
        if (w_svc_coin) begin
            if (w_pend[0]) begin
                w_clr[0]   = 1'b1;
                w_coin_val = CREDIT_W'(COIN0_VAL);
            end else if (w_pend[1]) begin
                w_clr[1]   = 1'b1;
                w_coin_val = CREDIT_W'(COIN1_VAL);
            end else begin
                w_clr[2]   = 1'b1;
                w_coin_val = CREDIT_W'(COIN2_VAL);
            end
        end
    end

    assign w_coin_sum   = widen(r_credit) + widen(w_coin_val);
    assign w_coin_fits  = (w_coin_sum <= SUM_W'(MAX_CREDIT));
    assign w_spend_fits = (r_spend_amt <= r_credit);

    // FSM, spend capture and credit arithmetic with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_spend_amt    <= '0;
            r_refund_amt   <= '0;
            r_spend_busy   <= 1'b0;
            r_spend_ok     <= 1'b0;
            r_spend_nak    <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_refund_valid <= 1'b0;
        end else begin
            r_spend_ok    <= 1'b0;
            r_spend_nak   <= 1'b0;
            r_coin_reject <= 1'b0;

            if (spend_req && !r_spend_busy) begin
                r_spend_busy <= 1'b1;
                r_spend_amt  <= spend_amount;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_svc_refund) begin
                        if (r_credit != '0) begin
                            r_refund_amt   <= r_credit;
                            r_credit       <= '0;
                            r_refund_valid <= 1'b1;
                            r_state        <= ST_REFUND;
                        end
                    end else if (w_svc_spend) begin
                        r_spend_busy <= 1'b0;
                        if (w_spend_fits) begin
                            r_credit   <= r_credit - r_spend_amt;
                            r_spend_ok <= 1'b1;
                        end else begin
                            r_spend_nak <= 1'b1;
                        end
                    end else if (w_svc_coin) begin
                        if (w_coin_fits) begin
                            r_credit <= w_coin_sum[CREDIT_W-1:0];
                        end else begin
                            r_coin_reject <= 1'b1;
                        end
                    end
                end
                ST_REFUND: begin
                    if (refund_ack && r_refund_valid) begin
                        r_refund_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign credit        = r_credit;
    assign spend_busy    = r_spend_busy;
    assign spend_ok      = r_spend_ok;
    assign spend_nak     = r_spend_nak;
    assign coin_reject   = r_coin_reject;
    assign refund_valid  = r_refund_valid;
    assign refund_amount = r_refund_amt;

endmodule

// File: tb/tb_coin_credit.sv
// Scoreboard bench for coin_credit: stimulus queues expected events, a monitor pops and compares.
module tb_coin_credit;

    typedef enum int {EV_CREDIT, EV_OK, EV_NAK, EV_REJ, EV_REFUND} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [3:0] debounced;
    logic       spend_req;
    logic [7:0] spend_amount;
    logic       refund_ack;
    logic [7:0] credit;
    logic       spend_busy;
    logic       spend_ok;
    logic       spend_nak;
    logic       coin_reject;
    logic       refund_valid;
    logic [7:0] refund_amount;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [7:0] m_prev_credit;
    logic       m_prev_rv;

    coin_credit dut (
        .clk           (clk),
        .reset         (reset),
        .debounced     (debounced),
        .spend_req     (spend_req),
        .spend_amount  (spend_amount),
        .refund_ack    (refund_ack),
        .credit        (credit),
        .spend_busy    (spend_busy),
        .spend_ok      (spend_ok),
        .spend_nak     (spend_nak),
        .coin_reject   (coin_reject),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input ev_kind_t k, input int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s val=%0d, required no event", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                errors++;
                $display("FAIL event_order: got %s val=%0d, required %s val=%0d",
                         k.name(), v, e.kind.name(), e.val);
            end
        end
    endtask

    // Monitor: every observable response in a cycle is one scoreboard event.
    always @(negedge clk) begin
        if (reset) begin
            m_prev_credit = credit;
            m_prev_rv     = refund_valid;
        end else begin
            if (spend_ok)                  check_event(EV_OK, 0);
            if (spend_nak)                 check_event(EV_NAK, 0);
            if (coin_reject)               check_event(EV_REJ, 0);
            if (refund_valid && !m_prev_rv) check_event(EV_REFUND, int'(refund_amount));
            if (credit != m_prev_credit)   check_event(EV_CREDIT, int'(credit));
            m_prev_credit = credit;
            m_prev_rv     = refund_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        debounced[b] = 1'b1;
        tick(2);
        debounced[b] = 1'b0;
        tick(2);
    endtask

    task automatic spend(input int amt);
        spend_req    = 1'b1;
        spend_amount = 8'(amt);
        tick(1);
        spend_req    = 1'b0;
        tick(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin
        reset        = 1'b1;
        debounced    = 4'b0001;
        spend_req    = 1'b0;
        spend_amount = 8'd0;
        refund_ack   = 1'b0;
        tick(3);
        chk("rst_credit", int'(credit), 0);
        chk("rst_spend_busy", int'(spend_busy), 0);
        chk("rst_refund_valid", int'(refund_valid), 0);
        chk("rst_refund_amount", int'(refund_amount), 0);

        // Button held through reset: no event.
        reset = 1'b0;
        tick(5);
        chk("held_through_reset_credit", int'(credit), 0);
        debounced = 4'b0000;
        tick(2);
        expect_ev(EV_CREDIT, 5);
        debounced = 4'b0001;
        tick(2);
        chk("coin0_latency_credit", int'(credit), 5);
        debounced = 4'b0000;
        tick(2);

        // Three coins rise together: serviced on consecutive cycles.
        do_reset();
        expect_ev(EV_CREDIT, 5);
        expect_ev(EV_CREDIT, 15);
        expect_ev(EV_CREDIT, 40);
        debounced = 4'b0111;
        tick(1);
        tick(1); chk("multi_c1", int'(credit), 5);
        tick(1); chk("multi_c2", int'(credit), 15);
        tick(1); chk("multi_c3", int'(credit), 40);
        debounced = 4'b0000;
        tick(2);

        // Credit ceiling.
        for (int i = 1; i <= 6; i++) begin
            expect_ev(EV_CREDIT, 40 + 25 * i);
            press(2);
        end
        expect_ev(EV_REJ, 0);
        press(2);
        chk("reject_keeps_credit", int'(credit), 190);
        expect_ev(EV_CREDIT, 200);
        press(1);
        expect_ev(EV_REJ, 0);
        press(0);
        chk("at_max_credit", int'(credit), 200);

        // Spend paths.
        do_reset();
        expect_ev(EV_CREDIT, 25); press(2);
        expect_ev(EV_CREDIT, 35); press(1);
        expect_ev(EV_CREDIT, 40); press(0);
        expect_ev(EV_NAK, 0);
        spend(50);
        chk("nak_credit", int'(credit), 40);
        expect_ev(EV_OK, 0);
        expect_ev(EV_CREDIT, 5);
        spend(35);
        chk("ok_credit", int'(credit), 5);
        expect_ev(EV_OK, 0);
        expect_ev(EV_CREDIT, 0);
        spend_req    = 1'b1;
        spend_amount = 8'd5;
        tick(1);
        chk("busy_after_capture", int'(spend_busy), 1);
        tick(1);
        spend_req = 1'b0;
        tick(4);
        chk("busy_cleared", int'(spend_busy), 0);
        expect_ev(EV_OK, 0);
        spend(0);

        // Refund with a coin arriving during REFUND.
        expect_ev(EV_CREDIT, 25); press(2);
        expect_ev(EV_CREDIT, 35); press(1);
        expect_ev(EV_CREDIT, 40); press(0);
        expect_ev(EV_REFUND, 40);
        expect_ev(EV_CREDIT, 0);
        press(3);
        press(0);
        tick(3);
        chk("refund_valid_held", int'(refund_valid), 1);
        chk("refund_amount_stable", int'(refund_amount), 40);
        chk("coin_waits_in_refund", int'(credit), 0);
        expect_ev(EV_CREDIT, 5);
        refund_ack = 1'b1;
        tick(1);
        refund_ack = 1'b0;
        chk("refund_valid_dropped", int'(refund_valid), 0);
        tick(3);
        chk("coin_after_ack", int'(credit), 5);

        // Refund with zero credit offers nothing.
        expect_ev(EV_OK, 0);
        expect_ev(EV_CREDIT, 0);
        spend(5);
        press(3);
        tick(3);
        chk("zero_refund_no_valid", int'(refund_valid), 0);

        // Asynchronous reset while a refund is offered.
        expect_ev(EV_CREDIT, 25);
        press(2);
        expect_ev(EV_REFUND, 25);
        expect_ev(EV_CREDIT, 0);
        press(3);
        chk("pre_reset_refund_valid", int'(refund_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_credit", int'(credit), 0);
        chk("async_refund_valid", int'(refund_valid), 0);
        chk("async_refund_amount", int'(refund_amount), 0);
        chk("async_spend_busy", int'(spend_busy), 0);
        chk("async_pulses", int'({spend_ok, spend_nak, coin_reject}), 0);
        tick(2);
        reset = 1'b0;
        tick(5);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
